// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, fetches over a req/ack memory port,
// feeds the IF/ID register, absorbs stalls in a one-entry hold buffer and
// drains an in-flight request after a branch redirect.
module if_fetch_unit #(
    parameter int unsigned     PC_W     = 12,
    parameter int unsigned     INSTR_W  = 19,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               stall,
    input  logic               branch_taken,
    input  logic [PC_W-1:0]    branch_target,
    output logic               imem_req,
    output logic [PC_W-1:0]    imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic [INSTR_W-1:0] instruction,
    output logic [PC_W-1:0]    pc,
    output logic               loadbar,
    output logic               flush
);

    localparam logic [1:0] ST_START = 2'd0;
    localparam logic [1:0] ST_FETCH = 2'd1;
    localparam logic [1:0] ST_HOLD  = 2'd2;
    localparam logic [1:0] ST_DRAIN = 2'd3;

    logic [1:0]         state;
    logic [1:0]         state_nxt;
    logic [PC_W-1:0]    pc_reg;
    logic [PC_W-1:0]    pc_nxt;
    logic [PC_W-1:0]    pc_inc;
    logic [PC_W-1:0]    drain_addr;
    logic [PC_W-1:0]    drain_nxt;
    logic [PC_W-1:0]    hold_pc;
    logic [PC_W-1:0]    hold_pc_nxt;
    logic [INSTR_W-1:0] hold_instr;
    logic [INSTR_W-1:0] hold_instr_nxt;
    logic [PC_W-1:0]    last_pc;
    logic [INSTR_W-1:0] last_instr;

    // Sequential PC increment, wraps modulo 2^PC_W.
    assign pc_inc = pc_reg + PC_W'(1);

    // State, PC, drain address, hold buffer and last-presented IF/ID values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= ST_START;
            pc_reg     <= RESET_PC;
            drain_addr <= RESET_PC;
            hold_pc    <= '0;
            hold_instr <= '0;
            last_pc    <= '0;
            last_instr <= '0;
        end else begin
            state      <= state_nxt;
            pc_reg     <= pc_nxt;
            drain_addr <= drain_nxt;
            hold_pc    <= hold_pc_nxt;
            hold_instr <= hold_instr_nxt;
            last_pc    <= pc;
            last_instr <= instruction;
        end
    end

    // Next-state logic and same-cycle memory / IF/ID controls.
    always_comb begin
        state_nxt      = state;
        pc_nxt         = pc_reg;
        drain_nxt      = drain_addr;
        hold_pc_nxt    = hold_pc;
        hold_instr_nxt = hold_instr;
        imem_req       = 1'b0;
        imem_addr      = pc_reg;
        loadbar        = 1'b1;
        flush          = branch_taken & reset;
        instruction    = last_instr;
        pc             = last_pc;

        case (state)
            ST_START: begin
                state_nxt = ST_FETCH;
                if (branch_taken) begin
                    pc_nxt = branch_target;
                end
            end

            ST_FETCH: begin
                imem_req = 1'b1;
                if (branch_taken) begin
                    pc_nxt = branch_target;
                    if (!imem_ack) begin
                        // Outstanding request must complete at its original address.
                        drain_nxt = pc_reg;
                        state_nxt = ST_DRAIN;
                    end
                end else if (imem_ack) begin
                    pc_nxt = pc_inc;
                    if (stall) begin
                        hold_instr_nxt = imem_rdata;
                        hold_pc_nxt    = pc_inc;
                        state_nxt      = ST_HOLD;
                    end else begin
                        loadbar     = 1'b0;
                        instruction = imem_rdata;
                        pc          = pc_inc;
                    end
                end
            end

            ST_HOLD: begin
                instruction = hold_instr;
                pc          = hold_pc;
                if (branch_taken) begin
                    pc_nxt    = branch_target;
                    state_nxt = ST_FETCH;
                end else if (!stall) begin
                    loadbar   = 1'b0;
                    state_nxt = ST_FETCH;
                end
            end

            ST_DRAIN: begin
                imem_req  = 1'b1;
                imem_addr = drain_addr;
                if (branch_taken) begin
                    pc_nxt = branch_target;
                end
                if (imem_ack) begin
                    state_nxt = ST_FETCH;
                end
            end

            default: begin
                state_nxt = ST_START;
            end
        endcase
    end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit with a memory model returning addr*3.
module tb_if_fetch_unit;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        branch_taken;
    logic [11:0] branch_target;
    logic        imem_req;
    logic [11:0] imem_addr;
    logic        imem_ack;
    logic [18:0] imem_rdata;
    logic [18:0] instruction;
    logic [11:0] pc;
    logic        loadbar;
    logic        flush;
    logic        mem_ok;

    int total;
    int bad;

    if_fetch_unit dut (
        .clk           (clk),
        .reset         (reset),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ack      (imem_ack),
        .imem_rdata    (imem_rdata),
        .instruction   (instruction),
        .pc            (pc),
        .loadbar       (loadbar),
        .flush         (flush)
    );

    // Memory: acks a pending request whenever mem_ok is set; data = addr*3.
    assign imem_ack   = imem_req & mem_ok;
    assign imem_rdata = 19'(imem_addr) * 19'd3;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        reset = 1'b0; stall = 1'b0; branch_taken = 1'b0; branch_target = '0; mem_ok = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL rst_req got=%0h exp=0", imem_req); end
        total++; if (imem_addr !== 12'h000) begin bad++; $display("FAIL rst_addr got=%0h exp=0", imem_addr); end
        total++; if (loadbar !== 1'b1) begin bad++; $display("FAIL rst_loadbar got=%0h exp=1", loadbar); end
        total++; if (flush !== 1'b0) begin bad++; $display("FAIL rst_flush got=%0h exp=0", flush); end
        total++; if (instruction !== 19'h0) begin bad++; $display("FAIL rst_instr got=%0h exp=0", instruction); end
        total++; if (pc !== 12'h0) begin bad++; $display("FAIL rst_pc got=%0h exp=0", pc); end
        @(negedge clk);
        reset = 1'b1;
        #1;
        total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL start_req got=%0h exp=0", imem_req); end
    endtask

    task automatic test_zero_wait();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            total++; if (imem_req !== 1'b1) begin bad++; $display("FAIL zw_req[%0d] got=%0h exp=1", i, imem_req); end
            total++; if (imem_addr !== 12'(i)) begin bad++; $display("FAIL zw_addr[%0d] got=%0h exp=%0h", i, imem_addr, i); end
            total++; if (loadbar !== 1'b0) begin bad++; $display("FAIL zw_loadbar[%0d] got=%0h exp=0", i, loadbar); end
            total++; if (pc !== 12'(i + 1)) begin bad++; $display("FAIL zw_pc[%0d] got=%0h exp=%0h", i, pc, i + 1); end
            total++; if (instruction !== 19'(3 * i)) begin bad++; $display("FAIL zw_instr[%0d] got=%0h exp=%0h", i, instruction, 3 * i); end
        end
    endtask

    task automatic test_stall();
        for (int i = 3; i < 5; i++) begin
            @(negedge clk);
            #1;
            total++; if (pc !== 12'(i + 1)) begin bad++; $display("FAIL st_pre_pc[%0d] got=%0h exp=%0h", i, pc, i + 1); end
        end
        @(negedge clk);
        stall = 1'b1;
        #1;
        total++; if (imem_addr !== 12'h005) begin bad++; $display("FAIL st_addr got=%0h exp=5", imem_addr); end
        total++; if (loadbar !== 1'b1) begin bad++; $display("FAIL st_ack_loadbar got=%0h exp=1", loadbar); end
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            #1;
            total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL st_hold_req[%0d] got=%0h exp=0", i, imem_req); end
            total++; if (loadbar !== 1'b1) begin bad++; $display("FAIL st_hold_loadbar[%0d] got=%0h exp=1", i, loadbar); end
            total++; if (instruction !== 19'd15) begin bad++; $display("FAIL st_hold_instr[%0d] got=%0h exp=f", i, instruction); end
            total++; if (pc !== 12'h006) begin bad++; $display("FAIL st_hold_pc[%0d] got=%0h exp=6", i, pc); end
        end
        @(negedge clk);
        stall = 1'b0;
        #1;
        total++; if (loadbar !== 1'b0) begin bad++; $display("FAIL st_rel_loadbar got=%0h exp=0", loadbar); end
        total++; if (pc !== 12'h006) begin bad++; $display("FAIL st_rel_pc got=%0h exp=6", pc); end
        total++; if (instruction !== 19'd15) begin bad++; $display("FAIL st_rel_instr got=%0h exp=f", instruction); end
        total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL st_rel_req got=%0h exp=0", imem_req); end
        @(negedge clk);
        #1;
        total++; if (imem_addr !== 12'h006) begin bad++; $display("FAIL st_next_addr got=%0h exp=6", imem_addr); end
        total++; if (pc !== 12'h007 || loadbar !== 1'b0) begin bad++; $display("FAIL st_next_pc got=%0h/%0h exp=7/0", pc, loadbar); end
    endtask

    task automatic test_branch_drain();
        @(negedge clk);
        #1;
        total++; if (imem_addr !== 12'h007) begin bad++; $display("FAIL bd_addr7 got=%0h exp=7", imem_addr); end
        @(negedge clk);
        mem_ok = 1'b0;
        #1;
        total++; if (imem_req !== 1'b1 || imem_addr !== 12'h008) begin bad++; $display("FAIL bd_wait1 got=%0h/%0h exp=1/8", imem_req, imem_addr); end
        total++; if (loadbar !== 1'b1 || flush !== 1'b0) begin bad++; $display("FAIL bd_wait1_ctl got=%0h/%0h exp=1/0", loadbar, flush); end
        @(negedge clk);
        branch_taken = 1'b1; branch_target = 12'h100;
        #1;
        total++; if (flush !== 1'b1 || loadbar !== 1'b1) begin bad++; $display("FAIL bd_branch_ctl got=%0h/%0h exp=1/1", flush, loadbar); end
        total++; if (imem_addr !== 12'h008) begin bad++; $display("FAIL bd_branch_addr got=%0h exp=8", imem_addr); end
        @(negedge clk);
        branch_taken = 1'b0;
        #1;
        total++; if (imem_req !== 1'b1 || imem_addr !== 12'h008) begin bad++; $display("FAIL bd_drain got=%0h/%0h exp=1/8", imem_req, imem_addr); end
        total++; if (flush !== 1'b0 || loadbar !== 1'b1) begin bad++; $display("FAIL bd_drain_ctl got=%0h/%0h exp=0/1", flush, loadbar); end
        @(negedge clk);
        mem_ok = 1'b1;
        #1;
        total++; if (imem_addr !== 12'h008 || loadbar !== 1'b1) begin bad++; $display("FAIL bd_drop got=%0h/%0h exp=8/1", imem_addr, loadbar); end
        @(negedge clk);
        #1;
        total++; if (imem_addr !== 12'h100) begin bad++; $display("FAIL bd_target_addr got=%0h exp=100", imem_addr); end
        total++; if (pc !== 12'h101 || instruction !== 19'h300) begin bad++; $display("FAIL bd_target_data got=%0h/%0h exp=101/300", pc, instruction); end
    endtask

    task automatic test_branch_in_hold();
        @(negedge clk);
        stall = 1'b1;
        #1;
        total++; if (imem_addr !== 12'h101 || loadbar !== 1'b1) begin bad++; $display("FAIL bh_ack got=%0h/%0h exp=101/1", imem_addr, loadbar); end
        @(negedge clk);
        branch_taken = 1'b1; branch_target = 12'h020;
        #1;
        total++; if (flush !== 1'b1 || loadbar !== 1'b1) begin bad++; $display("FAIL bh_ctl got=%0h/%0h exp=1/1", flush, loadbar); end
        total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL bh_req got=%0h exp=0", imem_req); end
        @(negedge clk);
        branch_taken = 1'b0; stall = 1'b0;
        #1;
        total++; if (imem_addr !== 12'h020 || imem_req !== 1'b1) begin bad++; $display("FAIL bh_target got=%0h/%0h exp=20/1", imem_addr, imem_req); end
        total++; if (pc !== 12'h021 || instruction !== 19'h060) begin bad++; $display("FAIL bh_data got=%0h/%0h exp=21/60", pc, instruction); end
        total++; if (loadbar !== 1'b0 || flush !== 1'b0) begin bad++; $display("FAIL bh_load got=%0h/%0h exp=0/0", loadbar, flush); end
    endtask

    task automatic test_pc_wrap();
        @(negedge clk);
        branch_taken = 1'b1; branch_target = 12'hFFF;
        #1;
        total++; if (flush !== 1'b1 || loadbar !== 1'b1) begin bad++; $display("FAIL pw_branch got=%0h/%0h exp=1/1", flush, loadbar); end
        @(negedge clk);
        branch_taken = 1'b0;
        #1;
        total++; if (imem_addr !== 12'hFFF) begin bad++; $display("FAIL pw_addr got=%0h exp=fff", imem_addr); end
        total++; if (pc !== 12'h000 || loadbar !== 1'b0) begin bad++; $display("FAIL pw_pc got=%0h/%0h exp=0/0", pc, loadbar); end
        total++; if (instruction !== 19'h2FFD) begin bad++; $display("FAIL pw_instr got=%0h exp=2ffd", instruction); end
        @(negedge clk);
        #1;
        total++; if (imem_addr !== 12'h000 || pc !== 12'h001) begin bad++; $display("FAIL pw_next got=%0h/%0h exp=0/1", imem_addr, pc); end
    endtask

    task automatic test_reset_mid_wait();
        @(negedge clk);
        mem_ok = 1'b0;
        #1;
        total++; if (imem_req !== 1'b1 || imem_addr !== 12'h001) begin bad++; $display("FAIL rm_wait got=%0h/%0h exp=1/1", imem_req, imem_addr); end
        #2;
        reset = 1'b0; branch_taken = 1'b1; branch_target = 12'h055;
        #1;
        total++; if (imem_req !== 1'b0 || loadbar !== 1'b1) begin bad++; $display("FAIL rm_ctl got=%0h/%0h exp=0/1", imem_req, loadbar); end
        total++; if (flush !== 1'b0) begin bad++; $display("FAIL rm_flush got=%0h exp=0", flush); end
        total++; if (imem_addr !== 12'h000) begin bad++; $display("FAIL rm_addr got=%0h exp=0", imem_addr); end
        total++; if (instruction !== 19'h0 || pc !== 12'h0) begin bad++; $display("FAIL rm_out got=%0h/%0h exp=0/0", instruction, pc); end
        @(negedge clk);
        branch_taken = 1'b0; mem_ok = 1'b1; reset = 1'b1;
        #1;
        total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL rm_start got=%0h exp=0", imem_req); end
        @(negedge clk);
        #1;
        total++; if (imem_addr !== 12'h000 || pc !== 12'h001 || loadbar !== 1'b0) begin bad++; $display("FAIL rm_refetch got=%0h/%0h/%0h exp=0/1/0", imem_addr, pc, loadbar); end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_zero_wait();
        test_stall();
        test_branch_drain();
        test_branch_in_hold();
        test_pc_wrap();
        test_reset_mid_wait();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
